// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the decode-side scoreboard.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // One-hot register mask for a register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    reg_onehot = NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/redirect_fsm.sv
// Redirect sequencer: squashes the fetch stream for the redirect cycle plus
// REDIRECT_FLUSH further cycles.
module redirect_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_FLUSH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_redirect,
  output logic squash
);

  localparam logic       FLUSH_EN = (REDIRECT_FLUSH > 0);
  localparam logic [1:0] RELOAD   = (REDIRECT_FLUSH > 0) ? 2'(REDIRECT_FLUSH - 1) : 2'd0;

  flush_state_t state, state_nxt;
  logic [1:0]   flush_cnt, flush_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    squash        = ex_redirect | (state == FLUSH);
    case (state)
      IDLE: begin
        if (ex_redirect && FLUSH_EN) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = RELOAD;
        end
      end
      FLUSH: begin
        // A fresh redirect restarts the squash window.
        if (ex_redirect) begin
          flush_cnt_nxt = RELOAD;
        end else if (flush_cnt == 2'd0) begin
          state_nxt = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard and IF/ID interlock for the 5-stage pipeline.
// Define WB_BYPASS_EN when the regfile writes before it is read in the same cycle.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_FLUSH = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1_idx,
  input  logic                 id_rs1_used,
  input  logic [4:0]           id_rs2_idx,
  input  logic                 id_rs2_used,
  input  logic                 id_reg_wr,
  input  logic [4:0]           id_rd_idx,
  input  logic                 wb_valid,
  input  logic                 wb_reg_wr,
  input  logic [4:0]           wb_rd_idx,
  input  logic                 ex_redirect,
  output logic                 stall,
  output logic                 id_issue,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic [31:0]          pending_vec,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                squash;
  logic                hazard;
  logic [NUM_REGS-1:0] wb_clr_mask;
  logic [NUM_REGS-1:0] id_set_mask;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] pending_nxt;

  redirect_fsm #(
    .REDIRECT_FLUSH(REDIRECT_FLUSH)
  ) u_redirect_fsm (
    .clk        (clk),
    .rst        (rst),
    .ex_redirect(ex_redirect),
    .squash     (squash)
  );

  assign wb_clr_mask = (wb_valid && wb_reg_wr) ? reg_onehot(wb_rd_idx) : '0;

`ifdef WB_BYPASS_EN
  // A register retiring this cycle is already readable from the regfile.
  assign busy = pending_vec & ~wb_clr_mask;
`else
  assign busy = pending_vec;
`endif

  // RAW on either source, or WAW on the destination.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (id_rs1_used && (id_rs1_idx != ZERO_REG) && busy[id_rs1_idx]) hazard = 1'b1;
      if (id_rs2_used && (id_rs2_idx != ZERO_REG) && busy[id_rs2_idx]) hazard = 1'b1;
      if (id_reg_wr   && (id_rd_idx  != ZERO_REG) && busy[id_rd_idx])  hazard = 1'b1;
    end
  end

  assign if_id_flush  = squash;
  assign stall        = hazard & ~squash;
  assign id_issue     = id_valid & ~hazard & ~squash;
  assign id_ex_bubble = ~id_issue;

  // Set after clear so a newly issued writer owns the register.
  assign id_set_mask = (id_issue && id_reg_wr && (id_rd_idx != ZERO_REG)) ?
                       reg_onehot(id_rd_idx) : '0;
  assign pending_nxt = ((pending_vec & ~wb_clr_mask) | id_set_mask) & ~NUM_REGS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_vec <= '0;
    end else begin
      pending_vec <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed scenarios plus random
// traffic compared against a pipeline-level reference model.
`timescale 1ns/1ps
module tb_pipe_scoreboard;

  localparam int unsigned RF      = 1;
  localparam int unsigned CW      = 4;
  localparam longint      CNT_MAX = (longint'(1) << CW) - 1;
`ifdef WB_BYPASS_EN
  localparam int EXP_RAW = 2;
`else
  localparam int EXP_RAW = 3;
`endif

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1_idx;
  logic          id_rs1_used;
  logic [4:0]    id_rs2_idx;
  logic          id_rs2_used;
  logic          id_reg_wr;
  logic [4:0]    id_rd_idx;
  logic          wb_valid;
  logic          wb_reg_wr;
  logic [4:0]    wb_rd_idx;
  logic          ex_redirect;
  logic          stall;
  logic          id_issue;
  logic          id_ex_bubble;
  logic          if_id_flush;
  logic [31:0]   pending_vec;
  logic [CW-1:0] stall_cnt;

  pipe_scoreboard #(
    .REDIRECT_FLUSH(RF),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1_idx  (id_rs1_idx),
    .id_rs1_used (id_rs1_used),
    .id_rs2_idx  (id_rs2_idx),
    .id_rs2_used (id_rs2_used),
    .id_reg_wr   (id_reg_wr),
    .id_rd_idx   (id_rd_idx),
    .wb_valid    (wb_valid),
    .wb_reg_wr   (wb_reg_wr),
    .wb_rd_idx   (wb_rd_idx),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .id_issue    (id_issue),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush (if_id_flush),
    .pending_vec (pending_vec),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of busy registers, squash window, stall count and
  // an EX/MEM/WB pipeline of issued instructions feeding writeback.
  typedef struct {
    bit         v;
    bit         wr;
    logic [4:0] rd;
  } slot_t;

  bit     m_pend [32];
  int     m_flush_left;
  longint m_stall_cnt;
  slot_t  slot [3];
  bit     m_squash, m_stall, m_issue;
  logic   obs_stall, obs_issue, obs_flush;

  function automatic bit reg_busy(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (slot[2].v && slot[2].wr && (slot[2].rd == idx)) return 1'b0;
`endif
    return m_pend[idx];
  endfunction

  function automatic logic [31:0] pend_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_pend[i];
    return w;
  endfunction

  task automatic set_inst(input bit v, input logic [4:0] rs1, input bit u1,
                          input logic [4:0] rs2, input bit u2, input bit wr,
                          input logic [4:0] rd);
    id_valid    = v;
    id_rs1_idx  = rs1;
    id_rs1_used = u1;
    id_rs2_idx  = rs2;
    id_rs2_used = u2;
    id_reg_wr   = wr;
    id_rd_idx   = rd;
  endtask

  task automatic set_idle();
    set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  // One clock: drive WB from the model pipeline, check outputs, advance model.
  task automatic cycle();
    bit hz;
    wb_valid  = slot[2].v;
    wb_reg_wr = slot[2].wr;
    wb_rd_idx = slot[2].rd;
    #1;
    hz = id_valid && ((id_rs1_used && reg_busy(id_rs1_idx)) ||
                      (id_rs2_used && reg_busy(id_rs2_idx)) ||
                      (id_reg_wr   && reg_busy(id_rd_idx)));
    m_squash  = ex_redirect || (m_flush_left > 0);
    m_stall   = hz && !m_squash;
    m_issue   = id_valid && !hz && !m_squash;
    obs_stall = stall;
    obs_issue = id_issue;
    obs_flush = if_id_flush;
    check_eq("stall",        32'(stall),        32'(m_stall));
    check_eq("id_issue",     32'(id_issue),     32'(m_issue));
    check_eq("id_ex_bubble", 32'(id_ex_bubble), 32'(!m_issue));
    check_eq("if_id_flush",  32'(if_id_flush),  32'(m_squash));
    check_eq("pending_vec",  pending_vec,       pend_word());
    check_eq("stall_cnt",    32'(stall_cnt),    32'(m_stall_cnt));
    @(posedge clk);
    if (slot[2].v && slot[2].wr) m_pend[slot[2].rd] = 1'b0;
    if (m_issue && id_reg_wr && (id_rd_idx != 5'd0)) m_pend[id_rd_idx] = 1'b1;
    if (m_stall && (m_stall_cnt < CNT_MAX)) m_stall_cnt++;
    if (ex_redirect) m_flush_left = RF;
    else if (m_flush_left > 0) m_flush_left--;
    slot[2] = slot[1];
    slot[1] = slot[0];
    slot[0] = '{m_issue, id_reg_wr, id_rd_idx};
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ex_redirect = 1'b0;
    wb_valid    = 1'b0;
    wb_reg_wr   = 1'b0;
    wb_rd_idx   = 5'd0;
    set_idle();
    #1;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    for (int i = 0; i < 3; i++) slot[i] = '{1'b0, 1'b0, 5'd0};
    m_flush_left = 0;
    m_stall_cnt  = 0;
    check_eq("rst_pending",   pending_vec,         32'h0);
    check_eq("rst_stall_cnt", 32'(stall_cnt),      32'h0);
    check_eq("rst_flush",     32'(if_id_flush),    32'h0);
    check_eq("rst_stall",     32'(stall),          32'h0);
    check_eq("rst_issue",     32'(id_issue),       32'h0);
    check_eq("rst_bubble",    32'(id_ex_bubble),   32'h1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    set_idle();
    ex_redirect = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int  nst;
    bit  done;
    do_reset();

    // Independent add issues at once and marks x5 busy.
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5);
    cycle();
    check_eq("add_x5_issue", 32'(obs_issue), 32'h1);
    check_eq("add_x5_stall", 32'(obs_stall), 32'h0);
    check_eq("add_x5_pend",  pending_vec,    32'h20);

    // Back-to-back dependent sub x6,x5,x3.
    set_inst(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6);
    nst  = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      cycle();
      if (obs_stall) nst++;
      if (obs_issue) done = 1'b1;
    end
    check_eq("raw_issued",       32'(done),      32'h1);
    check_eq("raw_stall_cycles", 32'(nst),       32'(EXP_RAW));
    check_eq("raw_stall_cnt",    32'(stall_cnt), 32'(EXP_RAW));
    drain(4);

    // Redirect pulse right after x7 issues: two squash cycles, x7 stays busy.
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7);
    cycle();
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8);
    ex_redirect = 1'b1;
    cycle();
    check_eq("redir_flush0", 32'(obs_flush), 32'h1);
    check_eq("redir_issue0", 32'(obs_issue), 32'h0);
    check_eq("redir_pend0",  pending_vec,    32'h80);
    ex_redirect = 1'b0;
    cycle();
    check_eq("redir_flush1", 32'(obs_flush), 32'h1);
    check_eq("redir_issue1", 32'(obs_issue), 32'h0);
    check_eq("redir_pend1",  pending_vec,    32'h80);
    cycle();
    check_eq("redir_flush2", 32'(obs_flush), 32'h0);
    check_eq("redir_issue2", 32'(obs_issue), 32'h1);
    drain(4);

    // Redirect while decode is stalled on x5.
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5);
    cycle();
    set_inst(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6);
    cycle();
    check_eq("stall_pre_redir", 32'(obs_stall), 32'h1);
    ex_redirect = 1'b1;
    cycle();
    check_eq("redir_stall", 32'(obs_stall), 32'h0);
    check_eq("redir_flush", 32'(obs_flush), 32'h1);
    check_eq("redir_issue", 32'(obs_issue), 32'h0);
    ex_redirect = 1'b0;
    set_idle();
    cycle();
    check_eq("x5_cleared", pending_vec, 32'h0);
    drain(3);

    // WB clear of x7 coincides with a new x7 writer issuing.
    slot[2] = '{1'b1, 1'b1, 5'd7};
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7);
    cycle();
    check_eq("setwins_issue", 32'(obs_issue), 32'h1);
    check_eq("setwins_pend",  pending_vec,    32'h80);
    drain(4);

    // Writes to x0 never mark anything busy.
    set_inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0);
    cycle();
    check_eq("x0_pend", pending_vec, 32'h0);
    set_inst(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd1);
    cycle();
    check_eq("x0_src_issue", 32'(obs_issue), 32'h1);
    check_eq("x0_src_stall", 32'(obs_stall), 32'h0);
    drain(4);

    // Reset while registers are busy and the flush window is open.
    set_inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
    cycle();
    set_inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    cycle();
    set_inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
    cycle();
    set_idle();
    ex_redirect = 1'b1;
    cycle();
    check_eq("prerst_pend", pending_vec, 32'h60);
    do_reset();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 1000) == 999) do_reset();
      ex_redirect = ($urandom_range(0, 11) == 0);
      cycle();
      if (m_squash) begin
        set_idle();
      end else if (!m_stall) begin
        set_inst($urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
